// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a sequential clear sweep (optional bypass: REGFILE_MP_BYPASS_EN).
// Latency: reads are combinational (0 cycles), writes land on the next edge, a sweep takes DEPTH cycles.
// Backpressure: none; writes presented while clr_busy is high are dropped, and clr_req is ignored during a sweep.
module regfile_mp #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*AWIDTH-1:0]  ra,
  output logic [NREAD*DWIDTH-1:0]  rdata,
  input  logic [1:0]               we,
  input  logic [2*AWIDTH-1:0]      wa,
  input  logic [2*DWIDTH-1:0]      wd,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] LAST = (AWIDTH+1)'(DEPTH - 1);
  localparam logic [AWIDTH:0] ONE  = (AWIDTH+1)'(1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [AWIDTH:0]   idx;
  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage, sweep controller and registered busy flag share one block so reset covers all of them at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '{default: '0};
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Port 1 is applied last so it wins on an address collision.
          for (int p = 0; p < 2; p++) begin
            if (we[p] && !(ZERO_REG != 0 && wa[p*AWIDTH +: AWIDTH] == '0))
              mem[wa[p*AWIDTH +: AWIDTH]] <= wd[p*DWIDTH +: DWIDTH];
          end
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[idx[AWIDTH-1:0]] <= '0;
          if (idx == LAST) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
          end else begin
            idx <= idx + ONE;
          end
        end
        default: begin
          state    <= IDLE;
          idx      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AWIDTH-1:0] a;
    logic [DWIDTH-1:0] q;

    assign a = ra[k*AWIDTH +: AWIDTH];

    always_comb begin
      q = mem[a];
`ifdef REGFILE_MP_BYPASS_EN
      // Forward only when the write will actually land, i.e. not during a sweep.
      if (state == IDLE) begin
        if (we[0] && wa[0 +: AWIDTH] == a)      q = wd[0 +: DWIDTH];
        if (we[1] && wa[AWIDTH +: AWIDTH] == a) q = wd[DWIDTH +: DWIDTH];
      end
`endif
      if (ZERO_REG != 0 && a == '0) q = '0;
    end

    assign rdata[k*DWIDTH +: DWIDTH] = q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 2-read instance and a 4-read instance.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [2*AW-1:0] ra;
  logic [2*DW-1:0] rdata;
  logic [1:0]      we;
  logic [2*AW-1:0] wa;
  logic [2*DW-1:0] wd;
  logic            clr_req;
  logic            clr_busy;

  logic [4*AW-1:0] ra4;
  logic [4*DW-1:0] rdata4;
  logic [1:0]      we4;
  logic [2*AW-1:0] wa4;
  logic [2*DW-1:0] wd4;
  logic            clr_req4;
  logic            clr_busy4;

  int total  = 0;
  int passed = 0;
  int cnt;

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rdata(rdata), .we(we), .wa(wa), .wd(wd),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(4), .ZERO_REG(1)) dut4 (
    .clk(clk), .rst(rst), .ra(ra4), .rdata(rdata4), .we(we4), .wa(wa4), .wd(wd4),
    .clr_req(clr_req4), .clr_busy(clr_busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0; clr_req = 1'b0;
    ra4 = '0; we4 = '0; wa4 = '0; wd4 = '0; clr_req4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state: busy low, every entry reads zero
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_busy4", {31'd0, clr_busy4}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra[AW-1:0] = i[AW-1:0];
      #1;
      chk("rst_entry", rdata[DW-1:0], 32'd0);
    end

    // Dual write to the same address: port 1 wins
    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h0000_BBBB, 32'h0000_AAAA}; ra[AW-1:0] = 5'd5;
    #1;
    chk("dual_same_cycle", rdata[DW-1:0], BYP ? 32'h0000_BBBB : 32'h0);
    tick();
    we = 2'b00;
    #1;
    chk("dual_next_cycle", rdata[DW-1:0], 32'h0000_BBBB);

    // Zero register ignores writes, including on the bypass path
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFF_FFFF}; ra[AW-1:0] = 5'd0;
    #1;
    chk("zero_same_cycle", rdata[DW-1:0], 32'h0);
    tick();
    we = 2'b00;
    #1;
    chk("zero_next_cycle", rdata[DW-1:0], 32'h0);

    // Bypass on read port 1
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'h0000_1234}; ra = {5'd7, 5'd5};
    #1;
    chk("byp_same_cycle", rdata[2*DW-1:DW], BYP ? 32'h0000_1234 : 32'h0);
    chk("byp_other_port", rdata[DW-1:0], 32'h0000_BBBB);
    tick();
    we = 2'b00;
    #1;
    chk("byp_next_cycle", rdata[2*DW-1:DW], 32'h0000_1234);

    // Fill all entries with 0x100+addr
    for (int i = 0; i < 32; i++) begin
      we = 2'b01; wa[AW-1:0] = i[AW-1:0]; wd[DW-1:0] = 32'h100 + i;
      tick();
    end
    we = 2'b00;
    ra = {5'd31, 5'd3};
    #1;
    chk("fill_3", rdata[DW-1:0], 32'h103);
    chk("fill_31", rdata[2*DW-1:DW], 32'h11F);

    // Clear sweep: 32 busy cycles, dropped write at cycle 10, clr_req ignored at 15
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      if (cnt == 10) begin
        ra = {5'd20, 5'd5}; we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEAD_BEEF};
        #1;
        chk("sweep_no_fwd", rdata[DW-1:0], 32'h0);
        chk("sweep_partial", rdata[2*DW-1:DW], 32'h114);
      end
      if (cnt == 15) clr_req = 1'b1;
      tick();
      we = 2'b00;
      clr_req = 1'b0;
      cnt++;
    end
    chk("sweep_len", cnt, 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra[AW-1:0] = i[AW-1:0];
      #1;
      chk("sweep_entry", rdata[DW-1:0], 32'd0);
    end

    // Reset in the middle of a sweep
    we = 2'b11; wa = {5'd30, 5'd3}; wd = {32'h3030, 32'h33};
    tick();
    we = 2'b00;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("mid_busy", {31'd0, clr_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra = {5'd30, 5'd3};
    #1;
    chk("rst_mid_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_mid_30", rdata[2*DW-1:DW], 32'h0);
    chk("rst_mid_3", rdata[DW-1:0], 32'h0);

    // Restarted sweep begins at index 0
    we = 2'b01; wa = {5'd0, 5'd1}; wd = {32'h0, 32'h55};
    tick();
    we = 2'b00;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    ra[AW-1:0] = 5'd1;
    #1;
    chk("restart_busy", {31'd0, clr_busy}, 32'd1);
    chk("restart_c0", rdata[DW-1:0], 32'h55);
    tick();
    tick();
    chk("restart_c2", rdata[DW-1:0], 32'h0);
    cnt = 2;
    while (clr_busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("restart_len", cnt, 32'd32);

    // Four read ports, each returning its own slice
    we4 = 2'b11; wa4 = {5'd9, 5'd6}; wd4 = {32'h22, 32'h11};
    tick();
    wa4 = {5'd31, 5'd17}; wd4 = {32'h44, 32'h33};
    tick();
    we4 = 2'b00;
    ra4 = {5'd31, 5'd17, 5'd9, 5'd6};
    #1;
    chk("r4_p0", rdata4[0*DW +: DW], 32'h11);
    chk("r4_p1", rdata4[1*DW +: DW], 32'h22);
    chk("r4_p2", rdata4[2*DW +: DW], 32'h33);
    chk("r4_p3", rdata4[3*DW +: DW], 32'h44);

    clr_req4 = 1'b1;
    tick();
    clr_req4 = 1'b0;
    cnt = 0;
    while (clr_busy4 === 1'b1 && cnt < 100) begin
      if (cnt == 5 || cnt == 31) clr_req4 = 1'b1;
      tick();
      clr_req4 = 1'b0;
      cnt++;
    end
    chk("r4_sweep_len", cnt, 32'd32);
    chk("r4_clr_p0", rdata4[0*DW +: DW], 32'h0);
    chk("r4_clr_p3", rdata4[3*DW +: DW], 32'h0);
    chk("r4_idle_busy", {31'd0, clr_busy4}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: data width per entry.
REQ-002 SHALL have parameter AWIDTH, default 5: address width; DEPTH = 2^AWIDTH entries.
REQ-003 SHALL have parameter NREAD, default 2, legal range 1..4: number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 = entry 0 is hardwired to zero.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports listed in REQ-006 and REQ-007.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port ra, input, NREAD*AWIDTH bits: read addresses; port k is at bits [k*AWIDTH +: AWIDTH].
REQ-009 SHALL have port rdata, output, NREAD*DWIDTH bits: read data; port k is at bits [k*DWIDTH +: DWIDTH].
REQ-010 SHALL have port we, input, 2 bits: write enables for write ports 0 and 1.
REQ-011 SHALL have port wa, input, 2*AWIDTH bits: write addresses, packed in the same way as ra.
REQ-012 SHALL have port wd, input, 2*DWIDTH bits: write data, packed in the same way as rdata.
REQ-013 SHALL have port clr_req, input, 1 bit: request to start a sequential clear sweep.
REQ-014 SHALL have port clr_busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-015 SHALL return storage[ra_k] combinationally on rdata_k, with zero cycles of read latency.
REQ-016 SHALL update an entry on the clock edge when its write enable is high, with write latency of 1 cycle.
REQ-017 SHALL give write port 1 priority when both write ports target the same address in the same cycle: the entry takes wd1.
REQ-018 SHALL, with ZERO_REG=1, ignore writes to address 0 and always read address 0 as 0, including on the bypass path.
REQ-019 SHALL have two controller states: IDLE and CLEAR.
REQ-020 SHALL move IDLE -> CLEAR on clr_req=1, and the sweep index SHALL start at 0.
REQ-021 SHALL, in CLEAR, write zero to entry[index] on each cycle and then increment index.
REQ-022 SHALL move CLEAR -> IDLE after index DEPTH-1 is cleared, so a sweep takes exactly DEPTH cycles.
REQ-023 SHALL drive clr_busy=1 in every CLEAR cycle and 0 in IDLE, as a registered output.
REQ-024 SHALL drop both write ports during CLEAR; reads stay functional and return the current partially cleared contents.
REQ-025 SHALL ignore clr_req while in CLEAR; the sweep does not restart.
REQ-026 SHALL not wrap the sweep index past DEPTH-1; the counter SHALL be AWIDTH+1 bits wide or use an explicit terminal compare.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set all DEPTH entries to 0 in that single cycle, set the state to IDLE, set index to 0, and drive clr_busy to 0.
REQ-028 SHALL give rst priority over writes, clr_req and an in-progress sweep; a sweep interrupted by reset is aborted.
REQ-029 SHALL give rdata the value 0 for every address in the cycle after reset.

Configuration
REQ-030 SHALL, when macro REGFILE_MP_BYPASS_EN is defined, forward a same-cycle write to a read of the same address, so rdata_k returns the incoming wd; port 1 takes precedence when both ports write that address.
REQ-031 SHALL, when REGFILE_MP_BYPASS_EN is undefined, return the pre-write storage value on rdata; the new value becomes visible from the next cycle.
REQ-032 SHALL not forward during CLEAR, because writes are dropped.

Verification
REQ-033 SHALL cover dual write: we=2'b11, wa0=wa1=5, wd0=0xAAAA, wd1=0xBBBB -> next cycle, ra0=5 returns 0xBBBB.
REQ-034 SHALL cover the zero register: ZERO_REG=1, we0=1, wa0=0, wd0=0xFFFF_FFFF -> ra0=0 returns 0, both in the same cycle with bypass enabled and in the next cycle.
REQ-035 SHALL cover bypass: write 0x1234 to address 7 while ra1=7 -> the same cycle returns 0x1234 with REGFILE_MP_BYPASS_EN defined, and the old value 0 without it.
REQ-036 SHALL cover a clear sweep: fill all 32 entries, pulse clr_req -> clr_busy high for exactly 32 cycles, every entry then reads 0, and a write issued at sweep cycle 10 is lost.
REQ-037 SHALL cover reset mid-sweep: assert rst at sweep cycle 12 -> next cycle clr_busy=0, state IDLE, all entries read 0, and a new clr_req restarts the sweep at index 0.
REQ-038 SHALL cover NREAD=4: four distinct addresses written with 0x11, 0x22, 0x33 and 0x44 -> each packed rdata slice returns its own value, and clr_req during the sweep has no effect on the 32-cycle duration.
